// File: rtl/alu_mc_if.sv
// Request/response bus for alu_mc.
//   in_valid/in_ready : request handshake carrying op, a, b
//   out_valid/out_ready : response handshake carrying result, flags
//   flags = {illegal, div_zero, gt, overflow, carry, zero}
interface alu_mc_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [5:0]       flags;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, flags
  );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU. Single-cycle ops complete one cycle after accept; MUL (shift-add) and
// DIV/MOD (restoring) iterate one bit per cycle for WIDTH cycles.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : alu_mc_if slave (request op/a/b, response result/flags)
module alu_mc #(
  parameter int unsigned WIDTH = 32
) (
  input logic     clk,
  input logic     rst,
  alu_mc_if.slave bus
);
  localparam int unsigned SHW = $clog2(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_CMP = 4'd2;
  localparam logic [3:0] OP_MUL = 4'd3;
  localparam logic [3:0] OP_LSL = 4'd4;
  localparam logic [3:0] OP_LSR = 4'd5;
  localparam logic [3:0] OP_ASR = 4'd6;
  localparam logic [3:0] OP_OR  = 4'd7;
  localparam logic [3:0] OP_NOT = 4'd8;
  localparam logic [3:0] OP_AND = 4'd9;
  localparam logic [3:0] OP_DIV = 4'd10;
  localparam logic [3:0] OP_MOD = 4'd11;
  localparam logic [3:0] OP_MOV = 4'd12;

  // Flag bit positions
  localparam int unsigned FL_ZERO  = 0;
  localparam int unsigned FL_CARRY = 1;
  localparam int unsigned FL_OVF   = 2;
  localparam int unsigned FL_GT    = 3;
  localparam int unsigned FL_DZ    = 4;
  localparam int unsigned FL_ILL   = 5;

  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  // acc: MUL high half / DIV partial remainder; lo: MUL multiplier+low half / DIV quotient
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [5:0]       flags_q, flags_d;

  // Single-cycle datapath, evaluated straight from the bus on the accept cycle
  logic [WIDTH-1:0] sc_result;
  logic [5:0]       sc_flags;
  logic [WIDTH:0]   sc_sum;
  logic [WIDTH:0]   sc_diff;
  logic             sc_big_shift;
  logic [SHW-1:0]   sc_shamt;
  logic             is_multi;

  always_comb begin
    sc_result    = '0;
    sc_flags     = '0;
    sc_sum       = {1'b0, bus.a} + {1'b0, bus.b};
    sc_diff      = {1'b0, bus.a} - {1'b0, bus.b};
    sc_big_shift = (bus.b >= WIDTH'(WIDTH));
    sc_shamt     = bus.b[SHW-1:0];
    is_multi     = (bus.op == OP_MUL) || (bus.op == OP_DIV) || (bus.op == OP_MOD);
    case (bus.op)
      OP_ADD: begin
        sc_result          = sc_sum[WIDTH-1:0];
        sc_flags[FL_CARRY] = sc_sum[WIDTH];
        sc_flags[FL_OVF]   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                             (sc_sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        sc_result          = sc_diff[WIDTH-1:0];
        sc_flags[FL_CARRY] = bus.a < bus.b;
        sc_flags[FL_OVF]   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                             (sc_diff[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_CMP: begin
        sc_flags[FL_GT]    = $signed(bus.a) > $signed(bus.b);
        sc_flags[FL_CARRY] = bus.a < bus.b;
      end
      OP_LSL:  sc_result = sc_big_shift ? '0 : (bus.a << sc_shamt);
      OP_LSR:  sc_result = sc_big_shift ? '0 : (bus.a >> sc_shamt);
      OP_ASR:  sc_result = sc_big_shift ? {WIDTH{bus.a[WIDTH-1]}}
                                        : WIDTH'($signed(bus.a) >>> sc_shamt);
      OP_OR:   sc_result = bus.a | bus.b;
      OP_NOT:  sc_result = ~bus.a;
      OP_AND:  sc_result = bus.a & bus.b;
      OP_MOV:  sc_result = bus.b;
      OP_MUL, OP_DIV, OP_MOD: sc_result = '0;
      default: sc_flags[FL_ILL] = 1'b1;
    endcase
    // CMP reports equality in zero instead of result==0
    sc_flags[FL_ZERO] = (bus.op == OP_CMP) ? (bus.a == bus.b) : (sc_result == '0);
  end

  // One iteration of the multi-cycle datapath
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic [WIDTH:0]   acc_it;
  logic [WIDTH-1:0] lo_it;
  logic [WIDTH-1:0] fin_result;
  logic [5:0]       fin_flags;

  always_comb begin
    mul_sum   = {1'b0, acc_q[WIDTH-1:0]} + (lo_q[0] ? {1'b0, a_q} : '0);
    div_shift = {acc_q[WIDTH-1:0], lo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_q};
    if (op_q == OP_MUL) begin
      acc_it = {1'b0, mul_sum[WIDTH:1]};
      lo_it  = {mul_sum[0], lo_q[WIDTH-1:1]};
    end else if (!div_diff[WIDTH]) begin
      acc_it = div_diff;
      lo_it  = {lo_q[WIDTH-2:0], 1'b1};
    end else begin
      acc_it = div_shift;
      lo_it  = {lo_q[WIDTH-2:0], 1'b0};
    end

    fin_flags = '0;
    case (op_q)
      OP_MUL: begin
        fin_result       = lo_it;
        fin_flags[FL_OVF] = |acc_it[WIDTH-1:0];
      end
      OP_DIV:  fin_result = (b_q == '0) ? '1 : lo_it;
      default: fin_result = (b_q == '0) ? a_q : acc_it[WIDTH-1:0];
    endcase
    fin_flags[FL_DZ]   = (op_q != OP_MUL) && (b_q == '0);
    fin_flags[FL_ZERO] = (fin_result == '0);
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    lo_d     = lo_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    flags_d  = flags_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          op_d = bus.op;
          a_d  = bus.a;
          b_d  = bus.b;
          if (is_multi) begin
            state_d = BUSY;
            cnt_d   = '0;
            acc_d   = '0;
            lo_d    = (bus.op == OP_MUL) ? bus.b : bus.a;
          end else begin
            state_d  = DONE;
            result_d = sc_result;
            flags_d  = sc_flags;
          end
        end
      end
      BUSY: begin
        acc_d = acc_it;
        lo_d  = lo_it;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d  = DONE;
          result_d = fin_result;
          flags_d  = fin_flags;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      lo_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      lo_q     <= lo_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = result_q;
  assign bus.flags     = flags_q;

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits, SHALL be legal for 8..64.
REQ-002 Parameter SHW, default $clog2(WIDTH), shift-amount width, SHALL be derived, not set by the user.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  operation request valid.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 op  input  4  opcode: 0 ADD, 1 SUB, 2 CMP, 3 MUL, 4 LSL, 5 LSR, 6 ASR, 7 OR, 8 NOT, 9 AND, 10 DIV, 11 MOD, 12 MOV, 13-15 illegal.
REQ-008 a, b  input  WIDTH each  operands, sampled only on accept.
REQ-009 out_valid  output  1  result and flags valid.
REQ-010 out_ready  input  1  consumer takes result.
REQ-011 result  output  WIDTH  operation result.
REQ-012 flags  output  6  {illegal, div_zero, gt, overflow, carry, zero} (bit 5..0).

Function
REQ-013 Accept SHALL occur on a cycle with in_valid && in_ready; a, b, op SHALL be registered on accept and later input changes SHALL be ignored.
REQ-014 FSM SHALL have states IDLE, BUSY, DONE; in_ready SHALL be 1 only in IDLE.
REQ-015 IDLE: accept of single-cycle op (all except MUL, DIV, MOD) -> DONE; accept of MUL/DIV/MOD -> BUSY; no accept -> IDLE.
REQ-016 BUSY SHALL run an iteration counter for exactly WIDTH cycles (one bit per cycle, shift-add multiply, restoring divide), then -> DONE.
REQ-017 DONE: out_valid SHALL be 1; result/flags SHALL be held stable until out_ready; out_valid && out_ready -> IDLE.
REQ-018 Latency accept-to-out_valid SHALL be 1 cycle for single-cycle ops and WIDTH+1 cycles for MUL/DIV/MOD; min back-to-back interval 2 cycles.
REQ-019 ADD/SUB: result = a+b / a-b modulo 2^WIDTH; carry = ADD carry-out / SUB borrow (a<b unsigned); overflow = signed two's-complement overflow.
REQ-020 CMP: result = 0; zero = (a==b); gt = signed(a) > signed(b); carry = unsigned a<b.
REQ-021 MUL: result = low WIDTH bits of unsigned a*b; overflow = 1 iff high WIDTH bits nonzero.
REQ-022 LSL/LSR/ASR: shift count = full unsigned b; count >= WIDTH SHALL give 0 for LSL/LSR and WIDTH copies of a[WIDTH-1] for ASR.
REQ-023 OR, AND: bitwise; NOT: ~a (b ignored); MOV: result = b.
REQ-024 DIV/MOD: unsigned; b==0 SHALL give DIV result all-ones, MOD result a, div_zero = 1, and still take WIDTH+1 cycles.
REQ-025 Illegal op: result 0, illegal = 1, single-cycle latency.
REQ-026 zero SHALL equal (result==0) for all ops except CMP (REQ-020); flags not defined for an op SHALL be 0.

Reset
REQ-027 rst SHALL force, on the next rising edge: state IDLE, in_ready 1, out_valid 0, result 0, flags 0, counter 0.
REQ-028 rst asserted in BUSY or DONE SHALL abort the operation and discard the result; rst has priority over accept and out_ready in the same cycle.
REQ-029 Request presented with rst asserted SHALL NOT be accepted.

Verification (WIDTH=32)
REQ-030 ADD a=FFFFFFFF, b=1 -> 1 cycle later result 0, zero 1, carry 1, overflow 0; ADD 7FFFFFFF+1 -> 80000000, overflow 1.
REQ-031 CMP a=FFFFFFFF(-1), b=1 -> gt 0, carry 0, zero 0; CMP a=5, b=5 -> zero 1, gt 0.
REQ-032 DIV a=100, b=7 -> out_valid exactly 33 cycles after accept, result 14; MOD same -> 2; DIV b=0 -> FFFFFFFF, div_zero 1.
REQ-033 MUL a=10000, b=10000 (hex) -> result 0, overflow 1; in_ready 0 throughout BUSY.
REQ-034 ASR a=80000000, b=40 -> FFFFFFFF; LSL b=32 -> 0; op=14 -> result 0, illegal 1.
REQ-035 Hold out_ready 0 for 5 cycles in DONE -> result stable, no new accept; rst at BUSY cycle 10 -> out_valid never asserts, in_ready 1 next cycle.
